paddle_sampler: RTL and testbench

Measures the pulse width of up to four Apple II game-port 558 timer outputs (PDL0–PDL3) and converts each to an 8-bit paddle value, so physical paddles/joysticks on the external port feed the same 0–255 range the emulated paddle path produces. It issues the shared timer trigger ($C070-equivalent strobe), times each channel's fall in 14 MHz wall-clock ticks, and publishes all values together with a one-cycle valid pulse. It sits between the external game-port pins and the IIgs I/O register logic.

---
 rtl/paddle_pkg.sv | 15 +
 rtl/paddle_channel_capture.sv | 69 ++++++
 rtl/paddle_sampler.sv | 201 ++++++++++++++++++++
 tb/tb_paddle_sampler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and default constants for the paddle_sampler game-port timer block.
package paddle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_SETTLE,
        ST_MEASURE,
        ST_DONE
    } state_e;

    localparam int DEF_TICKS_PER_UNIT = 158;
    localparam int DEF_MAX_UNITS      = 255;

endpackage

// File: rtl/paddle_channel_capture.sv
// One game-port timer channel: input synchronizer, capture flag, 8-bit paddle value and timeout bit.
// The *_next outputs expose this cycle's update so the top can publish results on the same edge.
module paddle_channel_capture
    import paddle_pkg::*;
#(
    parameter int MAX_UNITS = DEF_MAX_UNITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       paddle_in,
    input  logic       clear,
    input  logic       enable,
    input  logic       force_timeout,
    input  logic [7:0] unit_count,
    output logic       captured_next,
    output logic [7:0] value_next,
    output logic       timeout_next
);

    logic       sync1_q;
    logic       sync2_q;
    logic       captured_q;
    logic       captured_d;
    logic [7:0] value_q;
    logic [7:0] value_d;
    logic       timeout_q;
    logic       timeout_d;
    logic       fall;

    always_comb begin
        fall       = enable && !captured_q && !sync2_q;
        captured_d = captured_q;
        value_d    = value_q;
        timeout_d  = timeout_q;
        if (clear) begin
            captured_d = 1'b0;
            value_d    = 8'd0;
            timeout_d  = 1'b0;
        end else if (fall) begin
            captured_d = 1'b1;
            value_d    = unit_count;
        end else if (enable && !captured_q && force_timeout) begin
            // A fall seen in the expiry cycle still wins over the timeout.
            value_d    = 8'(MAX_UNITS);
            timeout_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            captured_q <= 1'b0;
            value_q    <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            sync1_q    <= paddle_in;
            sync2_q    <= sync1_q;
            captured_q <= captured_d;
            value_q    <= value_d;
            timeout_q  <= timeout_d;
        end
    end

    assign captured_next = captured_d;
    assign value_next    = value_d;
    assign timeout_next  = timeout_d;

endmodule

// File: rtl/paddle_sampler.sv
// Game-port paddle timer sampler: triggers the 558 timers, times four channels in paddle units.
// Optional PADDLE_SAMPLER_AUTO_EN: free-running sweeps separated by AUTO_GAP_TICKS idle ticks.
module paddle_sampler
    import paddle_pkg::*;
#(
    parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
    parameter int MAX_UNITS      = DEF_MAX_UNITS
`ifdef PADDLE_SAMPLER_AUTO_EN
    ,
    parameter int AUTO_GAP_TICKS = 14318
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tick_counter,
    input  logic        start,
    input  logic [3:0]  channel_mask,
    input  logic [3:0]  paddle_in,
    output logic        trigger,
    output logic [31:0] pdl_value,
    output logic [3:0]  timeout,
    output logic        valid,
    output logic        busy
);

    localparam int PRESC_W = $clog2(TICKS_PER_UNIT);

    state_e             state_q, state_d;
    logic [3:0]         mask_q, mask_d;
    logic [31:0]        tick_prev_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         unit_q, unit_d;
    logic               settle_q, settle_d;
    logic               trigger_q, valid_q, busy_q;
    logic [31:0]        pdl_q, pdl_d;
    logic [3:0]         tmo_q, tmo_d;

    logic               tick, wrap, sat_exit, all_done;
    logic               go, accept, load;
    logic [3:0]         go_mask;
    logic [3:0]         ch_enable, ch_captured, ch_timeout;
    logic [31:0]        ch_value;

`ifdef PADDLE_SAMPLER_AUTO_EN
    localparam int GAP_W = $clog2(AUTO_GAP_TICKS + 1);
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               armed_q, armed_d;
    logic               first_q, first_d;
    logic               auto_go;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_ch
        paddle_channel_capture #(
            .MAX_UNITS(MAX_UNITS)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .paddle_in    (paddle_in[i]),
            .clear        (accept),
            .enable       (ch_enable[i]),
            .force_timeout(sat_exit),
            .unit_count   (unit_q),
            .captured_next(ch_captured[i]),
            .value_next   (ch_value[i*8 +: 8]),
            .timeout_next (ch_timeout[i])
        );
    end

    always_comb begin
        // Inequality test keeps 32-bit wrap of the wall clock harmless.
        tick     = (tick_counter != tick_prev_q);
        wrap     = (state_q == ST_MEASURE) && tick &&
                   (presc_q == PRESC_W'(TICKS_PER_UNIT - 1));
        sat_exit = wrap && (unit_q == 8'(MAX_UNITS));
        all_done = &(ch_captured | ~mask_q);
`ifdef PADDLE_SAMPLER_AUTO_EN
        auto_go  = (first_q && channel_mask != 4'd0) ||
                   (armed_q && gap_q == GAP_W'(AUTO_GAP_TICKS));
        go       = start || auto_go;
        go_mask  = (start || first_q) ? channel_mask : mask_q;
`else
        go       = start;
        go_mask  = channel_mask;
`endif
        accept    = (state_q == ST_IDLE) && go;
        ch_enable = (state_q == ST_MEASURE) ? mask_q : 4'd0;

        state_d  = state_q;
        mask_d   = mask_q;
        presc_d  = presc_q;
        unit_d   = unit_q;
        settle_d = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mask_d  = go_mask;
                    state_d = (go_mask != 4'd0) ? ST_TRIG : ST_DONE;
                end
            end
            ST_TRIG: begin
                presc_d  = '0;
                unit_d   = 8'd0;
                settle_d = 1'b0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (tick) begin
                    if (wrap) begin
                        presc_d = '0;
                        if (unit_q != 8'(MAX_UNITS)) begin
                            unit_d = unit_q + 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                if (all_done || sat_exit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load  = (state_d == ST_DONE) && (state_q != ST_DONE);
        pdl_d = load ? ch_value : pdl_q;
        tmo_d = load ? ch_timeout : tmo_q;

`ifdef PADDLE_SAMPLER_AUTO_EN
        first_d = 1'b0;
        armed_d = armed_q;
        gap_d   = gap_q;
        if (state_q == ST_DONE) begin
            armed_d = (mask_q != 4'd0);
            gap_d   = '0;
        end else if (accept) begin
            armed_d = 1'b0;
            gap_d   = '0;
        end else if (state_q == ST_IDLE && armed_q && tick &&
                     gap_q != GAP_W'(AUTO_GAP_TICKS)) begin
            gap_d = gap_q + GAP_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= 4'd0;
            tick_prev_q <= 32'd0;
            presc_q     <= '0;
            unit_q      <= 8'd0;
            settle_q    <= 1'b0;
            trigger_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            pdl_q       <= 32'd0;
            tmo_q       <= 4'd0;
`ifdef PADDLE_SAMPLER_AUTO_EN
            gap_q       <= '0;
            armed_q     <= 1'b0;
            first_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            tick_prev_q <= tick_counter;
            presc_q     <= presc_d;
            unit_q      <= unit_d;
            settle_q    <= settle_d;
            trigger_q   <= (state_d == ST_TRIG);
            valid_q     <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            pdl_q       <= pdl_d;
            tmo_q       <= tmo_d;
`ifdef PADDLE_SAMPLER_AUTO_EN
            gap_q       <= gap_d;
            armed_q     <= armed_d;
            first_q     <= first_d;
`endif
        end
    end

    assign trigger   = trigger_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign pdl_value = pdl_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_paddle_sampler.sv
// Bench for paddle_sampler: randomized sweeps scored against a unit-arithmetic reference model.
module tb_paddle_sampler;

    localparam int TPU         = 158;
    localparam int MAXU        = 255;
    localparam int LIMIT_TICKS = (MAXU + 1) * TPU;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tick_counter;
    logic        start;
    logic [3:0]  channel_mask;
    logic [3:0]  paddle_in;
    logic        trigger;
    logic [31:0] pdl_value;
    logic [3:0]  timeout;
    logic        valid;
    logic        busy;

    paddle_sampler dut (
        .clk         (clk),
        .reset       (reset),
        .tick_counter(tick_counter),
        .start       (start),
        .channel_mask(channel_mask),
        .paddle_in   (paddle_in),
        .trigger     (trigger),
        .pdl_value   (pdl_value),
        .timeout     (timeout),
        .valid       (valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Sweep configuration, set by each scenario before calling sweep().
    int tgt_ticks[4];
    bit pre_low[4];
    int tick_pct;
    int restart_off;

    logic [31:0] exp_pdl;
    logic [3:0]  exp_tmo;

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sweep(input logic [3:0] mask, input string name);
        int  n, m0, v, t, c, i;
        bit  done, tk, all_cap;
        bit  cap[4];
        bit  dropped[4];
        int  fcyc[4];
        int  trig_cnt, trig_cyc, val_cnt, val_cyc, busy_bad;
        logic [31:0] seen_pdl;
        logic [3:0]  seen_tmo;
        bit  exp_busy;

        for (int k = 0; k < 4; k++) begin
            cap[k]     = 1'b0;
            dropped[k] = pre_low[k];
            fcyc[k]    = -100;
            paddle_in[k] = pre_low[k] ? 1'b0 : 1'b1;
        end
        start = 1'b0;
        repeat (3) next_cycle();

        channel_mask = mask;
        start        = 1'b1;
        n            = cyc;
        m0           = n + 4;
        t            = 0;
        v            = -1;
        done         = 1'b0;
        exp_pdl      = 32'd0;
        exp_tmo      = 4'd0;
        if (mask == 4'd0) begin
            v    = n + 1;
            done = 1'b1;
        end
        trig_cnt = 0; trig_cyc = -1; val_cnt = 0; val_cyc = -1; busy_bad = 0;
        seen_pdl = 32'hx; seen_tmo = 4'hx;

        forever begin
            next_cycle();
            c = cyc;
            start = (restart_off > 0 && c == n + restart_off);
            if (start) channel_mask = 4'($urandom_range(1, 15));

            if (trigger === 1'b1) begin trig_cnt++; trig_cyc = c; end
            if (valid === 1'b1) begin
                val_cnt++; val_cyc = c; seen_pdl = pdl_value; seen_tmo = timeout;
            end
            exp_busy = (c > n) && (!done || c <= v);
            if (busy !== exp_busy) busy_bad++;

            // Reference: a fall driven in cycle F is seen in F+2 (never before MEASURE),
            // worth floor(ticks elapsed in MEASURE so far / TPU).
            if (!done && c >= m0) begin
                for (i = 0; i < 4; i++) begin
                    if (mask[i] && !cap[i] && dropped[i] && c >= fcyc[i] + 2) begin
                        cap[i] = 1'b1;
                        exp_pdl[i*8 +: 8] = 8'(((t / TPU) > MAXU) ? MAXU : (t / TPU));
                    end
                end
            end

            tk = ($urandom_range(99) < tick_pct);
            if (tk) tick_counter = tick_counter + 32'd1;

            if (!done && c >= m0) begin
                if (tk) t++;
                all_cap = 1'b1;
                for (i = 0; i < 4; i++) if (mask[i] && !cap[i]) all_cap = 1'b0;
                if (all_cap) begin
                    v = c + 1; done = 1'b1;
                end else if (tk && t == LIMIT_TICKS) begin
                    for (i = 0; i < 4; i++) begin
                        if (mask[i] && !cap[i]) begin
                            exp_pdl[i*8 +: 8] = 8'(MAXU);
                            exp_tmo[i] = 1'b1;
                        end
                    end
                    v = c + 1; done = 1'b1;
                end
            end

            for (i = 0; i < 4; i++) begin
                if (!dropped[i] && tgt_ticks[i] >= 0 && c >= m0 && t >= tgt_ticks[i]) begin
                    dropped[i] = 1'b1; fcyc[i] = c; paddle_in[i] = 1'b0;
                end
            end

            if (done && c >= v + 2) break;
            if (c - n > 95000) begin
                errors++; checks++;
                $display("FAIL %s.budget: sweep did not complete, valid_count=%0d", name, val_cnt);
                break;
            end
        end

        checks++;
        if (trig_cnt !== ((mask != 4'd0) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s.trigger_count: got %0d expected %0d", name, trig_cnt, (mask != 4'd0) ? 1 : 0);
        end
        if (mask != 4'd0) begin
            checks++;
            if (trig_cyc !== n + 1) begin
                errors++;
                $display("FAIL %s.trigger_cycle: got %0d expected %0d", name, trig_cyc - n, 1);
            end
        end
        checks++;
        if (val_cnt !== 1) begin
            errors++;
            $display("FAIL %s.valid_count: got %0d expected 1", name, val_cnt);
        end
        checks++;
        if (val_cyc !== v) begin
            errors++;
            $display("FAIL %s.valid_cycle: got %0d expected %0d (relative to start)", name, val_cyc - n, v - n);
        end
        checks++;
        if (seen_pdl !== exp_pdl) begin
            errors++;
            $display("FAIL %s.pdl_value: got %08h expected %08h", name, seen_pdl, exp_pdl);
        end
        checks++;
        if (seen_tmo !== exp_tmo) begin
            errors++;
            $display("FAIL %s.timeout: got %04b expected %04b", name, seen_tmo, exp_tmo);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s.busy: %0d cycles wrong, expected 0", name, busy_bad);
        end
        checks++;
        if (pdl_value !== exp_pdl) begin
            errors++;
            $display("FAIL %s.pdl_hold: got %08h expected %08h", name, pdl_value, exp_pdl);
        end

        start     = 1'b0;
        paddle_in = 4'hF;
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < 4; k++) begin
            tgt_ticks[k] = -1;
            pre_low[k]   = 1'b0;
        end
        tick_pct    = 100;
        restart_off = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; channel_mask = 4'd0; paddle_in = 4'hF;
        tick_counter = 32'hFFFF_FF00;
        repeat (3) next_cycle();
        reset = 1'b0;
        next_cycle();
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset.trigger: got %b expected 0", trigger); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset.valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy: got %b expected 0", busy); end
        checks++; if (pdl_value !== 32'd0) begin errors++; $display("FAIL reset.pdl_value: got %08h expected 0", pdl_value); end
        checks++; if (timeout !== 4'd0) begin errors++; $display("FAIL reset.timeout: got %04b expected 0", timeout); end
    endtask

    task automatic test_single();
        clear_cfg();
        tgt_ticks[0] = TPU * 100 + 50;
        sweep(4'b0001, "single");
        checks++;
        if (pdl_value !== 32'h0000_0064 || timeout !== 4'd0) begin
            errors++;
            $display("FAIL single.abs: got %08h/%04b expected 00000064/0000", pdl_value, timeout);
        end
    endtask

    task automatic test_reset_mid();
        int vcount, tcount, bcount;
        paddle_in = 4'hF; start = 1'b0;
        repeat (2) next_cycle();
        channel_mask = 4'b0001; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (5) begin next_cycle(); tick_counter = tick_counter + 32'd1; end
        reset = 1'b1; start = 1'b1;
        next_cycle();
        reset = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid.busy: got %b expected 0", busy); end
        checks++; if (trigger !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL reset_mid.strobes: got trig=%b valid=%b expected 0/0", trigger, valid); end
        checks++; if (pdl_value !== 32'd0 || timeout !== 4'd0) begin errors++; $display("FAIL reset_mid.outputs: got %08h/%04b expected 0/0", pdl_value, timeout); end
        paddle_in[0] = 1'b0;
        vcount = 0; tcount = 0; bcount = 0;
        repeat (60) begin
            next_cycle();
            tick_counter = tick_counter + 32'd1;
            if (valid === 1'b1) vcount++;
            if (trigger === 1'b1) tcount++;
            if (busy !== 1'b0) bcount++;
        end
        checks++;
        if (vcount !== 0 || tcount !== 0 || bcount !== 0) begin
            errors++;
            $display("FAIL reset_mid.quiet: got valid=%0d trig=%0d busy=%0d expected 0/0/0", vcount, tcount, bcount);
        end
        paddle_in = 4'hF;
    endtask

    task automatic test_timeout_multi();
        clear_cfg();
        tgt_ticks[1] = TPU * 10 + 50;
        tgt_ticks[2] = TPU * 3;
        tgt_ticks[3] = TPU * 200 + 50;
        sweep(4'b1011, "timeout_multi");
        checks++;
        if (pdl_value !== {8'd200, 8'd0, 8'd10, 8'd255} || timeout !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_multi.abs: got %08h/%04b expected c8000aff/0001", pdl_value, timeout);
        end
    endtask

    task automatic test_mask_zero();
        clear_cfg();
        tgt_ticks[0] = 10;
        sweep(4'b0000, "mask_zero");
    endtask

    task automatic test_back_to_back();
        clear_cfg();
        pre_low[2]  = 1'b1;
        restart_off = 2;
        sweep(4'b0100, "prelow_busy");
        checks++;
        if (pdl_value !== 32'd0 || timeout !== 4'd0) begin
            errors++;
            $display("FAIL prelow_busy.abs: got %08h/%04b expected 0/0", pdl_value, timeout);
        end
        clear_cfg();
        tgt_ticks[0] = 5;
        tgt_ticks[1] = 400;
        sweep(4'b0011, "back_to_back");
    endtask

    task automatic test_random();
        logic [3:0] m;
        for (int r = 0; r < 4; r++) begin
            clear_cfg();
            tick_pct = $urandom_range(50, 100);
            for (int k = 0; k < 4; k++) begin
                tgt_ticks[k] = $urandom_range(0, 12 * TPU);
                pre_low[k]   = ($urandom_range(7) == 0);
            end
            m = 4'($urandom_range(1, 15));
            sweep(m, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_timeout_multi();
        test_mask_zero();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
